// File: rtl/stack_ctrl.sv
// stack_ctrl: stack controller that caches top-of-stack in a register and spills lower entries to a single-port RAM
module stack_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] tos,
  output logic [ADDR_W:0]   depth,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;
  localparam logic [1:0] OP_PUSH = 2'b01, OP_POP = 2'b10, OP_REPL = 2'b11;
  localparam logic [ADDR_W:0] MAX_DEPTH = (ADDR_W+1)'(2**ADDR_W + 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] sp, sp_n, addr_n;
  logic [ADDR_W:0] depth_n;
  logic [DATA_W-1:0] tos_n, wdata_n;
  logic wen_n, ovf_n, unf_n, empty, full;
  assign cmd_ready = (state == IDLE) && resetn;
  assign empty = depth == '0;
  assign full = depth == MAX_DEPTH;
  always_comb begin
    state_n = state;
    sp_n = sp;
    depth_n = depth;
    tos_n = tos;
    addr_n = ram_addr;
    wdata_n = ram_wdata;
    wen_n = 1'b0;
    ovf_n = overflow & ~clr_err;
    unf_n = underflow & ~clr_err;
    case (state)
      IDLE: if (cmd_valid) begin
        if (cmd_op == OP_PUSH) begin
          if (full) ovf_n = 1'b1;
          else begin
            tos_n = cmd_data;
            depth_n = depth + (ADDR_W+1)'(1);
            // the old TOS spills to RAM only when the stack was non-empty
            if (!empty) begin
              wdata_n = tos;
              addr_n = sp;
              wen_n = 1'b1;
              sp_n = sp + ADDR_W'(1);
              state_n = WR;
            end
          end
        end else if (cmd_op == OP_POP) begin
          if (empty) unf_n = 1'b1;
          else begin
            depth_n = depth - (ADDR_W+1)'(1);
            tos_n = '0;
            if (depth != (ADDR_W+1)'(1)) begin
              addr_n = sp - ADDR_W'(1);
              sp_n = sp - ADDR_W'(1);
              state_n = RD;
            end
          end
        end else if (cmd_op == OP_REPL) begin
          if (empty) unf_n = 1'b1;
          else tos_n = cmd_data;
        end
      end
      WR: state_n = IDLE;
      RD: state_n = CAP;
      default: begin
        tos_n = ram_rdata;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sp <= '0;
      depth <= '0;
      tos <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      ram_wen <= 1'b0;
    end else begin
      state <= state_n;
      sp <= sp_n;
      depth <= depth_n;
      tos <= tos_n;
      overflow <= ovf_n;
      underflow <= unf_n;
      ram_addr <= addr_n;
      ram_wdata <= wdata_n;
      ram_wen <= wen_n;
    end
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: scoreboard bench for stack_ctrl with a behavioural 256x32 registered-read RAM
module tb_stack_ctrl;
  logic clk = 1'b0, resetn, cmd_valid, clr_err, cmd_ready, overflow, underflow, ram_wen;
  logic [1:0] cmd_op;
  logic [31:0] cmd_data, tos, ram_wdata, ram_rdata;
  logic [8:0] depth;
  logic [7:0] ram_addr;
  logic [31:0] mem [256];
  logic [31:0] sb [$];
  int ncmp = 0, nfail = 0, wen_hi = 0;

  stack_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .tos(tos), .depth(depth), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  always @(negedge clk) if (ram_wen === 1'b1) wen_hi++;

  task automatic send(input logic [1:0] op, input logic [31:0] d, output int busy);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      ncmp++;
      nfail++;
      $display("FAIL send_timeout op=%0d: cmd_ready stayed 0, required 1", op);
    end
    @(posedge clk);
    @(negedge clk);
    busy = 0;
    while (!cmd_ready && busy < 20) begin
      @(negedge clk);
      busy++;
    end
    cmd_valid = 1'b0;
    if (op == 2'b01 && sb.size() < 257) sb.push_back(d);
    if (op == 2'b10 && sb.size() > 0) void'(sb.pop_back());
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_data = 32'hdead;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ncmp++; if (cmd_ready !== 1'b0) begin nfail++; $display("FAIL reset_ready_low got %0b exp 0", cmd_ready); end
    cmd_valid = 1'b0;
    resetn = 1'b1;
    #1;
    ncmp++; if ({depth, tos, overflow, underflow, ram_wen, ram_addr, ram_wdata} !== '0) begin
      nfail++; $display("FAIL reset_state depth=%0d tos=%h ovf=%0b unf=%0b wen=%0b addr=%h wdata=%h exp all 0",
        depth, tos, overflow, underflow, ram_wen, ram_addr, ram_wdata); end
    ncmp++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got %0b exp 1", cmd_ready); end
    sb.delete();
  endtask

  task automatic test_push_b2b();
    int b [3];
    int w0 = wen_hi;
    logic [31:0] v [3] = '{32'h11, 32'h22, 32'h33};
    foreach (v[i]) send(2'b01, v[i], b[i]);
    ncmp++; if (b[0] != 0 || b[1] != 1 || b[2] != 1) begin nfail++; $display("FAIL push_busy got %0d,%0d,%0d exp 0,1,1", b[0], b[1], b[2]); end
    ncmp++; if (depth !== 9'(sb.size())) begin nfail++; $display("FAIL push_depth got %0d exp %0d", depth, sb.size()); end
    ncmp++; if (tos !== sb[$]) begin nfail++; $display("FAIL push_tos got %h exp %h", tos, sb[$]); end
    ncmp++; if (mem[0] !== 32'h11 || mem[1] !== 32'h22) begin nfail++; $display("FAIL push_ram got %h,%h exp 11,22", mem[0], mem[1]); end
    ncmp++; if (wen_hi - w0 != 2) begin nfail++; $display("FAIL push_wen_cycles got %0d exp 2", wen_hi - w0); end
  endtask

  task automatic test_pop();
    int b;
    int w0 = wen_hi;
    repeat (2) begin
      send(2'b10, '0, b);
      ncmp++; if (b != 2) begin nfail++; $display("FAIL pop_busy got %0d exp 2", b); end
      ncmp++; if (tos !== sb[$]) begin nfail++; $display("FAIL pop_tos got %h exp %h", tos, sb[$]); end
      ncmp++; if (depth !== 9'(sb.size())) begin nfail++; $display("FAIL pop_depth got %0d exp %0d", depth, sb.size()); end
    end
    ncmp++; if (wen_hi != w0) begin nfail++; $display("FAIL pop_wen got %0d pulses exp 0", wen_hi - w0); end
  endtask

  task automatic test_underflow();
    int b;
    send(2'b10, '0, b);
    ncmp++; if (depth !== 9'd0 || tos !== 32'd0 || b != 0) begin nfail++; $display("FAIL pop_last depth=%0d tos=%h busy=%0d exp 0,0,0", depth, tos, b); end
    send(2'b10, '0, b);
    ncmp++; if (underflow !== 1'b1 || depth !== 9'd0) begin nfail++; $display("FAIL pop_empty unf=%0b depth=%0d exp 1,0", underflow, depth); end
    send(2'b11, 32'h5, b);
    ncmp++; if (underflow !== 1'b1 || tos !== 32'd0 || depth !== 9'd0) begin nfail++; $display("FAIL repl_empty unf=%0b tos=%h depth=%0d exp 1,0,0", underflow, tos, depth); end
  endtask

  task automatic test_replace();
    int b;
    send(2'b01, 32'h44, b);
    send(2'b01, 32'h55, b);
    send(2'b11, 32'h66, b);
    sb[$] = 32'h66;
    ncmp++; if (tos !== 32'h66 || depth !== 9'd2 || b != 0) begin nfail++; $display("FAIL replace tos=%h depth=%0d busy=%0d exp 66,2,0", tos, depth, b); end
    send(2'b10, '0, b);
    ncmp++; if (tos !== 32'h44) begin nfail++; $display("FAIL replace_pop tos=%h exp 44", tos); end
    send(2'b10, '0, b);
  endtask

  task automatic test_overflow();
    int b;
    clr_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b0;
    ncmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin nfail++; $display("FAIL clr_before_ovf ovf=%0b unf=%0b exp 0,0", overflow, underflow); end
    for (int i = 0; i < 257; i++) send(2'b01, 32'(i + 1), b);
    send(2'b01, 32'h999, b);
    ncmp++; if (overflow !== 1'b1 || depth !== 9'd257 || tos !== 32'd257) begin nfail++; $display("FAIL overflow ovf=%0b depth=%0d tos=%0d exp 1,257,257", overflow, depth, tos); end
    for (int i = 0; i < 257; i++) begin
      ncmp++; if (tos !== sb[$]) begin nfail++; $display("FAIL lifo_order idx=%0d tos=%0d exp %0d", i, tos, sb[$]); end
      send(2'b10, '0, b);
    end
    ncmp++; if (depth !== 9'd0 || tos !== 32'd0 || underflow !== 1'b0) begin nfail++; $display("FAIL drain depth=%0d tos=%h unf=%0b exp 0,0,0", depth, tos, underflow); end
  endtask

  task automatic test_clr_err();
    int b;
    clr_err = 1'b1;
    send(2'b10, '0, b);
    clr_err = 1'b0;
    ncmp++; if (underflow !== 1'b1 || overflow !== 1'b0) begin nfail++; $display("FAIL clr_and_err unf=%0b ovf=%0b exp 1,0", underflow, overflow); end
    clr_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b0;
    ncmp++; if (underflow !== 1'b0) begin nfail++; $display("FAIL clr_only unf=%0b exp 0", underflow); end
  endtask

  task automatic test_reset_mid_op();
    int b;
    for (int i = 1; i <= 3; i++) send(2'b01, 32'(i * 16), b);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    ncmp++; if (cmd_ready !== 1'b0) begin nfail++; $display("FAIL mid_busy ready=%0b exp 0", cmd_ready); end
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    sb.delete();
    ncmp++; if (depth !== 9'd0 || tos !== 32'd0 || cmd_ready !== 1'b1 || ram_wen !== 1'b0) begin
      nfail++; $display("FAIL mid_reset depth=%0d tos=%h ready=%0b wen=%0b exp 0,0,1,0", depth, tos, cmd_ready, ram_wen); end
    send(2'b01, 32'h7, b);
    ncmp++; if (depth !== 9'd1 || tos !== 32'h7) begin nfail++; $display("FAIL after_reset_push depth=%0d tos=%h exp 1,7", depth, tos); end
    @(posedge clk);
    @(negedge clk);
    ncmp++; if (cmd_ready !== 1'b1 || depth !== 9'd1) begin nfail++; $display("FAIL no_requeue ready=%0b depth=%0d exp 1,1", cmd_ready, depth); end
  endtask

  initial begin
    test_reset();
    test_push_b2b();
    test_pop();
    test_underflow();
    test_replace();
    test_overflow();
    test_clr_err();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
